sram_controller: RTL

Data-memory responder for the ARM pipeline. It serves the MEM stage's 32-bit word read/write requests from an external 16-bit asynchronous SRAM, splitting each word into two half-word accesses. It holds `ready` low for the duration of an access; the pipeline uses `~ready` as its Freeze.

---
 rtl/arm_mem_pkg.sv | 21 ++
 rtl/sram_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM pipeline data-memory path.
//   state_t           : sram_controller FSM states
//   op_t              : latched access direction
//   DATA_BASE_DEFAULT : byte address that maps to SRAM half-word 0
package arm_mem_pkg;

  localparam logic [31:0] DATA_BASE_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_LO = 2'd1,
    ACC_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/sram_controller.sv
// Data-memory responder: serves 32-bit word reads/writes from the MEM stage
// using two half-word accesses on an external 16-bit asynchronous SRAM.
// ready is low while an access is pending (the pipeline freezes on ~ready).
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   mem_r_en, mem_w_en  MEM stage read / write request
//   address, wdata      word-aligned byte address and write data
//   rdata, ready        read data (valid while ready after a read), not-busy
//   sram_addr           SRAM half-word address
//   sram_dq_o/_oe/_i    SRAM data out, drive enable, data in
//   sram_we_n           SRAM write enable, active low
//
// state  | meaning
// IDLE   | no access; ready follows ~(mem_r_en | mem_w_en)
// ACC_LO | low half-word access, HALF_CYCLES cycles
// ACC_HI | high half-word access, HALF_CYCLES cycles
// DONE   | ready high for one cycle, pipeline advances
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          SRAM_ADDR_W = 18,
  parameter int          HALF_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_o,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_i,
  output logic                   sram_we_n
);

  localparam int IDX_W = SRAM_ADDR_W - 1;
  localparam int CNT_W = $clog2(HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(HALF_CYCLES - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  op_t              op_q;

  logic [IDX_W-1:0] idx_next;
  logic             is_wr;

  // Out-of-range addresses wrap silently through the truncation.
  assign idx_next = IDX_W'((address - DATA_BASE) >> 2);
  assign is_wr    = (op_q == OP_WRITE);

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~(mem_r_en | mem_w_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Outputs are registered one edge ahead: the values loaded on an edge are
  // what the SRAM sees for the following cycle. The last cycle of each
  // half is a write hold cycle (we_n high, address/data still stable).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_q       <= OP_READ;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (mem_r_en | mem_w_en) begin
            idx_q      <= idx_next;
            wdata_q    <= wdata;
            op_q       <= mem_w_en ? OP_WRITE : OP_READ;
            cnt        <= '0;
            state      <= ACC_LO;
            sram_addr  <= {idx_next, 1'b0};
            sram_dq_o  <= wdata[15:0];
            sram_dq_oe <= mem_w_en;
            sram_we_n  <= ~mem_w_en;
          end
        end
        ACC_LO: begin
          if (cnt == CNT_LAST) begin
            if (!is_wr) rdata[15:0] <= sram_dq_i;
            cnt       <= '0;
            state     <= ACC_HI;
            sram_addr <= {idx_q, 1'b1};
            sram_dq_o <= wdata_q[31:16];
            sram_we_n <= ~is_wr;
          end else begin
            cnt       <= cnt + 1'b1;
            sram_we_n <= (cnt == CNT_PRELAST) ? 1'b1 : ~is_wr;
          end
        end
        ACC_HI: begin
          if (cnt == CNT_LAST) begin
            if (!is_wr) rdata[31:16] <= sram_dq_i;
            cnt        <= '0;
            state      <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            sram_we_n <= (cnt == CNT_PRELAST) ? 1'b1 : ~is_wr;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
